// File: rtl/mips_debug_unit_pkg.sv
// Shared definitions for the MIPS debug/sequencing controller: widths, command bytes,
// FSM state encoding and a byte-select helper.
package mips_debug_unit_pkg;

  localparam int unsigned LenData          = 32;
  localparam int unsigned LenAddr          = 8;
  localparam int unsigned NumRegs          = 8;
  localparam int unsigned DumpBytes        = 37;
  localparam int unsigned RstCyclesDefault = 2;

  localparam logic [LenData-1:0] HaltWordDefault = 32'hFFFF_FFFF;

  localparam logic [7:0] CmdLoad = 8'h4C;
  localparam logic [7:0] CmdCont = 8'h43;
  localparam logic [7:0] CmdStep = 8'h53;
  localparam logic [7:0] AckByte = 8'h4B;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StLoad     = 4'd1,
    StWrite    = 4'd2,
    StResetCpu = 4'd3,
    StRun      = 4'd4,
    StStep     = 4'd5,
    StTxSend   = 4'd6,
    StTxWait   = 4'd7
  } state_e;

  // sel 0 picks the most significant byte, so words stream MSB-first.
  function automatic logic [7:0] word_byte(input logic [LenData-1:0] word,
                                           input logic [1:0] sel);
    logic [7:0] b;
    unique case (sel)
      2'd0: b = word[31:24];
      2'd1: b = word[23:16];
      2'd2: b = word[15:8];
      2'd3: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mips_debug_unit_if.sv
// Bundles the UART handshakes and the pipeline-facing debug signals of the debug unit.
interface mips_debug_unit_if;
  import mips_debug_unit_pkg::*;

  logic [7:0]         rx_data;
  logic               rx_done;
  logic               tx_done;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic               halt_flag;
  logic [7:0]         in_pc;
  logic [LenData-1:0] in_reg0_recolector;
  logic [LenData-1:0] in_reg1_recolector;
  logic [LenData-1:0] in_reg2_recolector;
  logic [LenData-1:0] in_reg3_recolector;
  logic [LenData-1:0] in_reg4_recolector;
  logic [LenData-1:0] in_reg5_recolector;
  logic [LenData-1:0] in_reg6_recolector;
  logic [LenData-1:0] in_reg7_recolector;
  logic [LenData-1:0] in_mem_wire;
  logic               debug_flag;
  logic [LenAddr-1:0] out_addr_mem_inst;
  logic [LenData-1:0] out_ins_to_mem;
  logic               wea_ram_inst;
  logic               cpu_enable;
  logic               cpu_reset;
  logic [3:0]         state_leds;

  modport master (
    input  rx_data, rx_done, tx_done, halt_flag, in_pc,
    input  in_reg0_recolector, in_reg1_recolector, in_reg2_recolector, in_reg3_recolector,
    input  in_reg4_recolector, in_reg5_recolector, in_reg6_recolector, in_reg7_recolector,
    input  in_mem_wire,
    output tx_data, tx_start, debug_flag, out_addr_mem_inst, out_ins_to_mem, wea_ram_inst,
    output cpu_enable, cpu_reset, state_leds
  );

  modport slave (
    output rx_data, rx_done, tx_done, halt_flag, in_pc,
    output in_reg0_recolector, in_reg1_recolector, in_reg2_recolector, in_reg3_recolector,
    output in_reg4_recolector, in_reg5_recolector, in_reg6_recolector, in_reg7_recolector,
    output in_mem_wire,
    input  tx_data, tx_start, debug_flag, out_addr_mem_inst, out_ins_to_mem, wea_ram_inst,
    input  cpu_enable, cpu_reset, state_leds
  );

endinterface

// File: rtl/mips_debug_unit_tx_serializer.sv
// Debug tx serializer: byte-index counter, dump byte mux and tx handshake. In ack mode the
// sequence is a single 'K' byte; otherwise it is the 37-byte PC/register/memory dump.
module mips_debug_unit_tx_serializer
  import mips_debug_unit_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            ack_mode,
  input  logic                            sending,
  input  logic                            waiting,
  input  logic                            tx_done,
  input  logic [7:0]                      pc,
  input  logic [NumRegs-1:0][LenData-1:0] regs,
  input  logic [LenData-1:0]              mem,
  output logic [7:0]                      tx_data,
  output logic                            tx_start,
  output logic                            byte_done,
  output logic                            seq_done
);

  logic [5:0] idx_q, idx_d;
  logic       ack_q, ack_d;
  logic       last;
  logic [5:0] k;
  logic [7:0] byte_sel;

  assign last      = ack_q | (idx_q == 6'(DumpBytes - 1));
  assign byte_done = waiting & tx_done;
  assign seq_done  = byte_done & last;
  assign tx_start  = sending;

  always_comb begin
    ack_d = ack_q;
    idx_d = idx_q;
    if (start) begin
      ack_d = ack_mode;
      idx_d = '0;
    end else if (byte_done) begin
      idx_d = last ? 6'd0 : idx_q + 6'd1;
    end
  end

  // Index 0 is the PC; k = idx-1 walks reg0..reg7 (k < 32) then the memory word.
  always_comb begin
    k = idx_q - 6'd1;
    if (ack_q) begin
      byte_sel = AckByte;
    end else if (idx_q == 6'd0) begin
      byte_sel = pc;
    end else if (k[5]) begin
      byte_sel = word_byte(mem, k[1:0]);
    end else begin
      byte_sel = word_byte(regs[k[4:2]], k[1:0]);
    end
  end

  // Inputs are frozen while transmitting, so the muxed byte holds until tx_done.
  assign tx_data = (sending | waiting) ? byte_sel : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      ack_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      ack_q <= ack_d;
    end
  end

endmodule

// File: rtl/mips_debug_unit.sv
// Debug/sequencing controller for the 5-stage MIPS pipeline: program load over UART,
// continuous or single-step execution gating, and state dump back to the host.
module mips_debug_unit
  import mips_debug_unit_pkg::*;
#(
  parameter logic [LenData-1:0] HaltWord  = HaltWordDefault,
  parameter int unsigned        RstCycles = RstCyclesDefault
) (
  input  logic              clk,
  input  logic              reset,
  mips_debug_unit_if.master bus
);

  state_e             state_q, state_d;
  logic [LenAddr-1:0] addr_q, addr_d;
  logic [LenData-1:0] word_q, word_d;
  logic [1:0]         bcnt_q, bcnt_d;
  logic [7:0]         rcnt_q, rcnt_d;
  logic               released_q;

  logic ser_start, ser_ack, byte_done, seq_done;
  logic end_of_load, is_cmd_load, is_cmd_exec, wr_en;
  logic [NumRegs-1:0][LenData-1:0] regs;

  assign regs = {bus.in_reg7_recolector, bus.in_reg6_recolector, bus.in_reg5_recolector,
                 bus.in_reg4_recolector, bus.in_reg3_recolector, bus.in_reg2_recolector,
                 bus.in_reg1_recolector, bus.in_reg0_recolector};

  assign end_of_load = (word_q == HaltWord) | (addr_q == '1);
  assign is_cmd_load = bus.rx_data == CmdLoad;
  assign is_cmd_exec = (bus.rx_data == CmdCont) | (bus.rx_data == CmdStep);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      word_q     <= '0;
      bcnt_q     <= '0;
      rcnt_q     <= '0;
      released_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      bcnt_q     <= bcnt_d;
      rcnt_q     <= rcnt_d;
      released_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    ser_start = 1'b0;
    ser_ack   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.rx_done && is_cmd_load) begin
          state_d = StLoad;
        end else if (bus.rx_done && is_cmd_exec) begin
          if (bus.halt_flag) begin
            state_d   = StTxSend;
            ser_start = 1'b1;
          end else begin
            state_d = (bus.rx_data == CmdCont) ? StRun : StStep;
          end
        end
      end
      StLoad:     if (bus.rx_done && bcnt_q == 2'd3) state_d = StWrite;
      StWrite:    state_d = end_of_load ? StResetCpu : StLoad;
      StResetCpu: begin
        if (rcnt_q == 8'(RstCycles - 1)) begin
          state_d   = StTxSend;
          ser_start = 1'b1;
          ser_ack   = 1'b1;
        end
      end
      StRun: begin
        if (bus.halt_flag) begin
          state_d   = StTxSend;
          ser_start = 1'b1;
        end
      end
      StStep: begin
        state_d   = StTxSend;
        ser_start = 1'b1;
      end
      StTxSend:   state_d = StTxWait;
      StTxWait: begin
        if (seq_done) begin
          state_d = StIdle;
        end else if (byte_done) begin
          state_d = StTxSend;
        end
      end
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    word_d = word_q;
    bcnt_d = bcnt_q;
    rcnt_d = rcnt_q;
    if (state_q == StIdle && bus.rx_done && is_cmd_load) begin
      addr_d = '0;
      bcnt_d = '0;
    end
    if (state_q == StLoad && bus.rx_done) begin
      word_d = {word_q[LenData-9:0], bus.rx_data};
      bcnt_d = bcnt_q + 2'd1;
    end
    // The last address is not incremented so the counter never wraps to 0.
    if (state_q == StWrite) begin
      if (!end_of_load) addr_d = addr_q + 1'b1;
      rcnt_d = '0;
    end
    if (state_q == StResetCpu) rcnt_d = rcnt_q + 8'd1;
  end

  assign wr_en = state_q == StWrite;

  always_comb begin
    bus.debug_flag        = (state_q == StLoad) | wr_en;
    bus.wea_ram_inst      = wr_en;
    bus.out_addr_mem_inst = wr_en ? addr_q : '0;
    bus.out_ins_to_mem    = wr_en ? word_q : '0;
    bus.cpu_enable        = ((state_q == StRun) & ~bus.halt_flag) | (state_q == StStep);
    bus.cpu_reset         = released_q & (state_q != StResetCpu);
    bus.state_leds        = state_q;
  end

  mips_debug_unit_tx_serializer u_tx_serializer (
    .clk       (clk),
    .rst_n     (reset),
    .start     (ser_start),
    .ack_mode  (ser_ack),
    .sending   (state_q == StTxSend),
    .waiting   (state_q == StTxWait),
    .tx_done   (bus.tx_done),
    .pc        (bus.in_pc),
    .regs      (regs),
    .mem       (bus.in_mem_wire),
    .tx_data   (bus.tx_data),
    .tx_start  (bus.tx_start),
    .byte_done (byte_done),
    .seq_done  (seq_done)
  );

endmodule

// File: tb/tb_mips_debug_unit.sv
// Scoreboard bench for mips_debug_unit: expected writes and tx bytes are queued as stimulus
// is driven and compared by a negedge monitor as the DUT produces them.
module tb_mips_debug_unit;
  import mips_debug_unit_pkg::*;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mips_debug_unit_if bus ();

  mips_debug_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int en_cnt = 0;
  int crst_cnt = 0;
  int wr_cnt = 0;
  int ts_cnt = 0;
  int tx_delay = 3;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];

  logic [7:0]  pc_v;
  logic [31:0] reg_v[8];
  logic [31:0] mem_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: event counters plus scoreboard comparison of writes and tx bytes.
  initial begin
    wr_t w;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.cpu_enable) en_cnt++;
        if (!bus.cpu_reset) crst_cnt++;
        if (bus.cpu_enable || bus.wea_ram_inst || bus.tx_start)
          check("excl", 32'($countones({bus.cpu_enable, bus.wea_ram_inst, bus.tx_start})), 1);
        if (bus.wea_ram_inst) begin
          wr_cnt++;
          if (exp_wr.size() == 0) begin
            check("wr_extra", 32'(exp_wr.size()), 1);
          end else begin
            w = exp_wr.pop_front();
            check("wr_addr", {24'h0, bus.out_addr_mem_inst}, {24'h0, w.addr});
            check("wr_data", bus.out_ins_to_mem, w.data);
          end
        end
        if (bus.tx_start) begin
          ts_cnt++;
          if (exp_tx.size() == 0) begin
            check("tx_extra", 32'(exp_tx.size()), 1);
          end else begin
            b = exp_tx.pop_front();
            check("tx_byte", {24'h0, bus.tx_data}, {24'h0, b});
          end
        end
      end
    end
  end

  // UART tx model: answers each tx_start with a tx_done pulse after tx_delay cycles.
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && bus.tx_start) begin
        repeat (tx_delay) @(posedge clk);
        #1 bus.tx_done = 1'b1;
        @(posedge clk);
        #1 bus.tx_done = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_err %0d", n_err);
    $fatal(1);
  end

  task automatic send_rx(input logic [7:0] b);
    @(posedge clk);
    #1 bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge clk);
    #1 bus.rx_done = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_rx(w[8*i +: 8]);
  endtask

  task automatic apply_snapshot();
    bus.in_pc = pc_v;
    bus.in_reg0_recolector = reg_v[0];
    bus.in_reg1_recolector = reg_v[1];
    bus.in_reg2_recolector = reg_v[2];
    bus.in_reg3_recolector = reg_v[3];
    bus.in_reg4_recolector = reg_v[4];
    bus.in_reg5_recolector = reg_v[5];
    bus.in_reg6_recolector = reg_v[6];
    bus.in_reg7_recolector = reg_v[7];
    bus.in_mem_wire = mem_v;
  endtask

  task automatic push_dump();
    exp_tx.push_back(pc_v);
    for (int r = 0; r < 8; r++)
      for (int i = 3; i >= 0; i--) exp_tx.push_back(reg_v[r][8*i +: 8]);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(mem_v[8*i +: 8]);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (exp_tx.size() == 0 && exp_wr.size() == 0 && bus.state_leds == 4'd0) break;
    end
    check({tag, "_pending"}, 32'(exp_tx.size() + exp_wr.size()), 0);
    check({tag, "_idle"}, {28'h0, bus.state_leds}, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_leds"}, {28'h0, bus.state_leds}, 0);
    check({tag, "_cpu_reset"}, {31'h0, bus.cpu_reset}, 0);
    check({tag, "_cpu_enable"}, {31'h0, bus.cpu_enable}, 0);
    check({tag, "_wea"}, {31'h0, bus.wea_ram_inst}, 0);
    check({tag, "_debug_flag"}, {31'h0, bus.debug_flag}, 0);
    check({tag, "_tx_start"}, {31'h0, bus.tx_start}, 0);
    check({tag, "_tx_data"}, {24'h0, bus.tx_data}, 0);
    check({tag, "_addr"}, {24'h0, bus.out_addr_mem_inst}, 0);
    check({tag, "_ins"}, bus.out_ins_to_mem, 0);
  endtask

  initial begin
    int base_en, base_crst, base_wr, base_ts;
    logic [31:0] w;

    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    bus.halt_flag = 1'b0;
    pc_v = 8'h3C;
    for (int r = 0; r < 8; r++) reg_v[r] = 32'h1000_0001 * (r + 1);
    reg_v[0] = 32'hA1B2_C3D4;
    mem_v = 32'hDEAD_BEEF;
    apply_snapshot();

    // Power-up reset
    repeat (3) @(posedge clk);
    #1 check_all_zero("por");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1 check({"por_rel_cpu_reset"}, {31'h0, bus.cpu_reset}, 1);
    check("por_rel_leds", {28'h0, bus.state_leds}, 0);

    // Reset in the middle of a load discards the partial word
    send_rx(CmdLoad);
    send_rx(8'h99);
    send_rx(8'h88);
    @(negedge clk);
    #1 check("mid_load_leds", {28'h0, bus.state_leds}, 1);
    check("mid_load_debug_flag", {31'h0, bus.debug_flag}, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1 check("mid_rel_cpu_reset", {31'h0, bus.cpu_reset}, 1);
    check("mid_rel_leds", {28'h0, bus.state_leds}, 0);

    // Short program terminated by the halt word, then a 2-cycle pipeline reset and ack
    base_crst = crst_cnt;
    exp_wr.push_back('{addr: 8'h00, data: 32'h2001_0005});
    exp_wr.push_back('{addr: 8'h01, data: 32'hFFFF_FFFF});
    exp_tx.push_back(AckByte);
    send_rx(CmdLoad);
    send_word(32'h2001_0005);
    send_word(32'hFFFF_FFFF);
    wait_drain("load_halt", 200);
    check("load_halt_cpu_reset_cycles", 32'(crst_cnt - base_crst), 2);

    // Continuous run, halt raised after 10 enable cycles
    apply_snapshot();
    push_dump();
    base_en = en_cnt;
    send_rx(CmdCont);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (en_cnt - base_en >= 10) break;
    end
    @(posedge clk);
    #1 bus.halt_flag = 1'b1;
    wait_drain("run", 1000);
    check("run_enable_cycles", 32'(en_cnt - base_en), 10);
    bus.halt_flag = 1'b0;

    // Two single steps with different snapshots
    for (int s = 0; s < 2; s++) begin
      pc_v = 8'h40 + 8'(s * 4);
      for (int r = 0; r < 8; r++) reg_v[r] = reg_v[r] ^ (32'h0F0F_5A5A << s);
      mem_v = 32'h0123_4567 + 32'(s);
      apply_snapshot();
      push_dump();
      base_en = en_cnt;
      send_rx(CmdStep);
      wait_drain("step", 1000);
      check("step_enable_cycles", 32'(en_cnt - base_en), 1);
    end

    // With halt already high, commands go straight to the dump
    bus.halt_flag = 1'b1;
    pc_v = 8'hE0;
    apply_snapshot();
    push_dump();
    base_en = en_cnt;
    send_rx(CmdStep);
    wait_drain("halted_step", 1000);
    check("halted_step_enables", 32'(en_cnt - base_en), 0);
    push_dump();
    send_rx(CmdCont);
    wait_drain("halted_cont", 1000);
    check("halted_cont_enables", 32'(en_cnt - base_en), 0);
    bus.halt_flag = 1'b0;

    // Full 256-word load; every word carries a 0x43 data byte
    base_crst = crst_cnt;
    base_wr = wr_cnt;
    for (int i = 0; i < 256; i++) begin
      w = {8'h10, 8'(i), 8'h43, ~8'(i)};
      exp_wr.push_back('{addr: 8'(i), data: w});
    end
    exp_tx.push_back(AckByte);
    send_rx(CmdLoad);
    for (int i = 0; i < 256; i++) begin
      w = {8'h10, 8'(i), 8'h43, ~8'(i)};
      send_word(w);
    end
    wait_drain("full_load", 500);
    check("full_load_writes", 32'(wr_cnt - base_wr), 256);
    check("full_load_cpu_reset_cycles", 32'(crst_cnt - base_crst), 2);

    // tx_done withheld: no re-pulse, byte held, stray command ignored
    pc_v = 8'h77;
    apply_snapshot();
    push_dump();
    base_en = en_cnt;
    base_ts = ts_cnt;
    tx_delay = 1000;
    send_rx(CmdStep);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (ts_cnt - base_ts >= 1) break;
    end
    tx_delay = 3;
    repeat (200) @(negedge clk);
    send_rx(CmdStep);
    repeat (300) @(negedge clk);
    #1 check("hold_tx_start_count", 32'(ts_cnt - base_ts), 1);
    check("hold_tx_data", {24'h0, bus.tx_data}, 32'h77);
    check("hold_leds", {28'h0, bus.state_leds}, 7);
    check("hold_tx_start_low", {31'h0, bus.tx_start}, 0);
    wait_drain("hold", 2000);
    repeat (20) @(negedge clk);
    #1 check("hold_enable_cycles", 32'(en_cnt - base_en), 1);
    check("hold_total_bytes", 32'(ts_cnt - base_ts), 37);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_debug_unit.md
Name: mips_debug_unit

Overview:
Debug/sequencing controller for the 5-stage MIPS pipeline. It sits between a byte-wide UART (rx/tx handshakes) and the pipeline top-level. It loads programs into instruction memory through the pipeline's debug write port and gates pipeline advance for continuous or single-step execution. After each run or step it streams PC, register-file snapshot registers 0..7 and the debug memory word back to the host.

Parameters:
len_data, 32, instruction/register word width
len_addr, 8, instruction-memory address width
HALT_WORD, 32'hFFFFFFFF, instruction encoding that terminates a program load
RST_CYCLES, 2, length of the pipeline reset pulse issued after a load
DUMP_BYTES, 37, bytes per dump: 1 PC + 8×4 registers + 4 memory

Ports:
clk  in  1  system clock
reset  in  1  reset; asynchronous, active-low
rx_data  in  8  received UART byte
rx_done  in  1  one-cycle pulse, rx_data valid
tx_done  in  1  one-cycle pulse, previous tx byte finished
tx_data  out  8  byte to transmit
tx_start  out  1  one-cycle pulse, start transmitting tx_data
halt_flag  in  1  pipeline halt reached (WB stage)
in_pc  in  8  pipeline PC low byte
in_reg0_recolector..in_reg7_recolector  in  len_data each  register snapshots 0..7
in_mem_wire  in  len_data  debug data-memory word
debug_flag  out  1  high while instruction memory is owned by this block
out_addr_mem_inst  out  len_addr  instruction-memory write address
out_ins_to_mem  out  len_data  instruction-memory write data
wea_ram_inst  out  1  instruction-memory write enable
cpu_enable  out  1  pipeline advances on a clock edge only while high
cpu_reset  out  1  pipeline reset, active-low
state_leds  out  4  current FSM state encoding

Behaviour:
- Reset (asynchronous): state IDLE. cpu_reset=0. All other outputs 0; internal counters 0. First clk after release: cpu_reset=1.
- Commands are accepted only in IDLE, on rx_done. ASCII 'L'(8'h4C) = load; 'C'(8'h43) = continuous run; 'S'(8'h53) = single step. Other bytes are ignored. rx_done in any other state is ignored, except inside LOAD.
- LOAD:
  - debug_flag=1; address counter=0.
  - Bytes assemble MSB-first: the first byte lands in [31:24].
  - On the 4th byte, WRITE (1 cycle): wea_ram_inst=1, out_addr_mem_inst=counter, out_ins_to_mem=word. Counter increments.
  - Load ends after the write of a word equal to HALT_WORD, or after the write at address 2^len_addr−1 (no wrap).
  - On end: debug_flag=0, then RESET_CPU.
- RESET_CPU: cpu_reset=0 for exactly RST_CYCLES cycles. Then send ack byte 'K'(8'h4B) via the tx handshake. Then IDLE.
- RUN: cpu_enable=1 every cycle until halt_flag is sampled high. cpu_enable drops in the same cycle halt_flag is seen (combinational gate). Then DUMP.
- STEP: cpu_enable=1 for exactly one cycle, then DUMP.
- 'C' or 'S' when halt_flag is already high: no enable cycle, go straight to DUMP.
- DUMP:
  - Byte index 0..DUMP_BYTES−1. Byte 0 = in_pc. Bytes 1..32 = reg0..reg7, each MSB-first. Bytes 33..36 = in_mem_wire, MSB-first.
  - Per byte: TX_SEND asserts tx_start for 1 cycle with tx_data, then TX_WAIT holds until tx_done. tx_data stays stable until tx_done.
  - cpu_enable=0 throughout, so inputs are stable.
  - After the last tx_done, go to IDLE.
- tx_done outside TX_WAIT is ignored. rx_done and tx_done in the same cycle are each handled independently by their owning state.
- cpu_enable, wea_ram_inst and tx_start are never asserted simultaneously.
- Reset mid-load or mid-dump: abort immediately. Partial word discarded; the host must resend.
- state_leds: IDLE=0, LOAD=1, WRITE=2, RESET_CPU=3, RUN=4, STEP=5, TX_SEND=6, TX_WAIT=7.

Decomposition:
- Shared package: state encodings, command byte constants, ACK byte, HALT_WORD default.
- One natural sub-module, debug_tx_serializer: byte-index counter, 37-way byte mux and tx handshake, with start/done pulses to the FSM. The ack byte uses the same serializer with length 1.

Test Plan:
1. Reset low mid-operation → all outputs 0, cpu_reset=0. After release: cpu_reset=1, state_leds=0.
2. 'L', then bytes 20 01 00 05, then FF FF FF FF → writes: addr0=32'h20010005, addr1=32'hFFFFFFFF, wea one cycle each. Then cpu_reset low exactly 2 cycles, then tx byte 8'h4B.
3. 'C' with halt_flag rising after 10 cycles → cpu_enable high exactly 10 cycles. Then 37 tx bytes: byte0=in_pc, bytes1–4 = reg0 MSB-first (reg0=32'hA1B2C3D4 gives A1 B2 C3 D4), bytes 33–36 = in_mem_wire.
4. 'S' twice → exactly one cpu_enable cycle per command, each followed by a 37-byte dump. With halt_flag=1: zero enable cycles, dump only.
5. Load 256 non-halt words → final write at addr 8'hFF, load ends without wrap, ack sent. A 0x43 byte received mid-load is treated as data.
6. tx_done withheld 1000 cycles → tx_start not re-pulsed, tx_data held. Stray rx 'S' during the dump is ignored.
